// File: rtl/nrisc_pkg.sv
// nrisc_pkg: types and constants shared by the nrisc program loader and its helpers.
package nrisc_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 8;
  localparam int COUNT_W = ADDR_W + 1;

  // Opcodes of the form 110xxx11 stop the core.
  localparam logic [DATA_W-1:0] HALT_MASK    = 8'b1110_0011;
  localparam logic [DATA_W-1:0] HALT_PATTERN = 8'b1100_0011;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_LOAD,
    ST_RUN,
    ST_HALTED,
    ST_ERR
  } loader_state_t;

  function automatic logic is_halt_opcode(input logic [DATA_W-1:0] instr);
    return (instr & HALT_MASK) == HALT_PATTERN;
  endfunction

endpackage

// File: rtl/halt_match.sv
// halt_match: purely combinational masked compare of the fetched instruction
// against the halt opcode pattern. Holds no state.
module halt_match
  import nrisc_pkg::*;
(
  input  logic [DATA_W-1:0] instr,
  output logic              match
);

  assign match = is_halt_opcode(instr);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a program as a byte stream, writes it into program
// memory, then releases the nrisc core until it fetches a halt opcode.
// Optional feature macro PROG_LOADER_CLEAR_EN: when defined, memory is zeroed
// (CLEAR phase) after reset and after every restart before loading begins;
// when undefined the loader starts directly in LOAD and memory is preserved.
//
// Writes are registered: a byte accepted on one edge is presented on
// mem_addr/mem_wdata/mem_we during the following cycle. The state moves to
// RUN or ERR on that same acceptance edge, so the final byte's write is still
// visible in the first RUN/ERR cycle; those states never start a new write.
module prog_loader
  import nrisc_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic               c,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_we,
  input  logic [DATA_W-1:0]  mem_instr,
  output logic               cpu_run,
  output logic               halt,
  input  logic               restart,
  output logic [COUNT_W-1:0] load_count,
  output logic               err
);

`ifdef PROG_LOADER_CLEAR_EN
  localparam loader_state_t     START_STATE = ST_CLEAR;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
`else
  localparam loader_state_t     START_STATE = ST_LOAD;
`endif
  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(DEPTH - 1);

  loader_state_t       state;
  loader_state_t       next_state;
  logic [ADDR_W-1:0]   wr_addr;
  logic                ready_q;
  logic                accept;
  logic                halt_hit;

  halt_match u_halt_match (
    .instr (mem_instr),
    .match (halt_hit)
  );

  assign in_ready = ready_q;
  assign accept   = in_valid && ready_q && (state == ST_LOAD);

  // State register; reset lands in the first phase of a fresh load.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state <= START_STATE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection and state-decoded core control outputs.
  always_comb begin
    next_state = state;
    cpu_run    = 1'b0;
    halt       = 1'b0;
    err        = 1'b0;
    case (state)
`ifdef PROG_LOADER_CLEAR_EN
      ST_CLEAR: begin
        if (wr_addr == LAST_ADDR) begin
          next_state = ST_LOAD;
        end
      end
`endif
      ST_LOAD: begin
        if (accept) begin
          if (in_last) begin
            next_state = ST_RUN;
          end else if (load_count == LAST_COUNT) begin
            next_state = ST_ERR;
          end
        end
      end
      ST_RUN: begin
        cpu_run = 1'b1;
        if (halt_hit) begin
          next_state = ST_HALTED;
        end
      end
      ST_HALTED: begin
        halt = 1'b1;
        if (restart) begin
          next_state = START_STATE;
        end
      end
      ST_ERR: begin
        halt = 1'b1;
        err  = 1'b1;
        if (restart) begin
          next_state = START_STATE;
        end
      end
      default: begin
        next_state = START_STATE;
      end
    endcase
  end

  // Write port, address pointer, byte counter and registered ready.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr    <= '0;
      load_count <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ready_q    <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      ready_q <= (next_state == ST_LOAD);
      case (state)
`ifdef PROG_LOADER_CLEAR_EN
        ST_CLEAR: begin
          mem_we    <= 1'b1;
          mem_addr  <= wr_addr;
          mem_wdata <= '0;
          wr_addr   <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
        end
`endif
        ST_LOAD: begin
          if (accept) begin
            mem_we     <= 1'b1;
            mem_addr   <= wr_addr;
            mem_wdata  <= in_data;
            wr_addr    <= wr_addr + 1'b1;
            load_count <= load_count + 1'b1;
          end
        end
        ST_HALTED, ST_ERR: begin
          if (restart) begin
            wr_addr    <= '0;
            load_count <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader. Two instances
// (DEPTH=16 and DEPTH=4) share stimulus; 'sel' routes in_valid/restart to one
// of them and picks which instance's outputs are observed.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_last;
  logic       restart;
  logic       sel;
  logic [7:0] in_data;
  logic [7:0] mem_instr;

  logic       rdy16, we16, run16, hlt16, err16;
  logic [7:0] addr16, wd16;
  logic [8:0] cnt16;
  logic       rdy4, we4, run4, hlt4, err4;
  logic [7:0] addr4, wd4;
  logic [8:0] cnt4;

  logic       rdy, we, run, hlt, er;
  logic [7:0] addr, wd;
  logic [8:0] cnt;

  int checks = 0;
  int errors = 0;

  assign rdy  = sel ? rdy4  : rdy16;
  assign we   = sel ? we4   : we16;
  assign run  = sel ? run4  : run16;
  assign hlt  = sel ? hlt4  : hlt16;
  assign er   = sel ? err4  : err16;
  assign addr = sel ? addr4 : addr16;
  assign wd   = sel ? wd4   : wd16;
  assign cnt  = sel ? cnt4  : cnt16;

  always #5 clk = ~clk;

  prog_loader #(.DEPTH(16)) u16 (
    .c          (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid & ~sel),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (rdy16),
    .mem_addr   (addr16),
    .mem_wdata  (wd16),
    .mem_we     (we16),
    .mem_instr  (mem_instr),
    .cpu_run    (run16),
    .halt       (hlt16),
    .restart    (restart & ~sel),
    .load_count (cnt16),
    .err        (err16)
  );

  prog_loader #(.DEPTH(4)) u4 (
    .c          (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid & sel),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (rdy4),
    .mem_addr   (addr4),
    .mem_wdata  (wd4),
    .mem_we     (we4),
    .mem_instr  (mem_instr),
    .cpu_run    (run4),
    .halt       (hlt4),
    .restart    (restart & sel),
    .load_count (cnt4),
    .err        (err4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    tick();
  endtask

  task automatic checkWrite(input string tag, input logic [7:0] a, input logic [7:0] d);
    checkOutput({tag, "_we"}, 32'(we), 32'd1);
    checkOutput({tag, "_addr"}, 32'(addr), 32'(a));
    checkOutput({tag, "_data"}, 32'(wd), 32'(d));
  endtask

  task automatic checkClear(input int depth);
`ifdef PROG_LOADER_CLEAR_EN
    for (int i = 0; i < depth; i++) begin
      tick();
      checkWrite($sformatf("clear%0d", i), 8'(i), 8'h00);
      checkOutput($sformatf("clear%0d_ready", i), 32'(rdy), 32'(i == depth - 1));
    end
`else
    tick();
    checkOutput($sformatf("load_ready_d%0d", depth), 32'(rdy), 32'd1);
    checkOutput($sformatf("no_clear_we_d%0d", depth), 32'(we), 32'd0);
`endif
  endtask

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence covering reset, load, halt, overflow, restart and abort.
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = 8'h00;
    restart   = 1'b0;
    sel       = 1'b0;
    mem_instr = 8'h00;
    tick();
    tick();

    checkOutput("rst_ready", 32'(rdy), 32'd0);
    checkOutput("rst_we", 32'(we), 32'd0);
    checkOutput("rst_run", 32'(run), 32'd0);
    checkOutput("rst_halt", 32'(hlt), 32'd0);
    checkOutput("rst_err", 32'(er), 32'd0);
    checkOutput("rst_count", 32'(cnt), 32'd0);
    checkOutput("rst_addr", 32'(addr), 32'd0);
    checkOutput("rst_wdata", 32'(wd), 32'd0);
    checkOutput("rst_u4_ready", 32'(rdy4), 32'd0);
    checkOutput("rst_u4_we", 32'(we4), 32'd0);

    rst_n = 1'b1;
    checkClear(16);

    applyStimulus(1'b1, 8'h11, 1'b0);
    checkWrite("b0", 8'd0, 8'h11);
    checkOutput("b0_count", 32'(cnt), 32'd1);
    applyStimulus(1'b1, 8'h22, 1'b0);
    checkWrite("b1", 8'd1, 8'h22);
    applyStimulus(1'b1, 8'h33, 1'b1);
    checkWrite("b2", 8'd2, 8'h33);
    checkOutput("b2_count", 32'(cnt), 32'd3);
    checkOutput("b2_run", 32'(run), 32'd1);
    checkOutput("b2_ready", 32'(rdy), 32'd0);
    in_valid = 1'b0;
    in_last  = 1'b0;

    restart = 1'b1;
    tick();
    restart = 1'b0;
    checkOutput("run_restart_ignored", 32'(run), 32'd1);
    checkOutput("run_count_kept", 32'(cnt), 32'd3);
    checkOutput("run_no_we", 32'(we), 32'd0);

    mem_instr = 8'b1111_0111;
    tick();
    checkOutput("nomatch1_halt", 32'(hlt), 32'd0);
    checkOutput("nomatch1_run", 32'(run), 32'd1);
    mem_instr = 8'b1100_0010;
    tick();
    checkOutput("nomatch2_halt", 32'(hlt), 32'd0);
    mem_instr = 8'b1101_0011;
    tick();
    checkOutput("match_halt", 32'(hlt), 32'd1);
    checkOutput("match_run", 32'(run), 32'd0);
    checkOutput("match_err", 32'(er), 32'd0);
    checkOutput("halted_we", 32'(we), 32'd0);
    mem_instr = 8'h00;

    sel = 1'b1;
    #1;
    checkOutput("d4_ready", 32'(rdy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
      checkWrite($sformatf("ovf%0d", i), 8'(i), 8'hA0 + 8'(i));
    end
    checkOutput("ovf_err", 32'(er), 32'd1);
    checkOutput("ovf_halt", 32'(hlt), 32'd1);
    checkOutput("ovf_run", 32'(run), 32'd0);
    checkOutput("ovf_count", 32'(cnt), 32'd4);
    checkOutput("ovf_ready", 32'(rdy), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("err_no_we", 32'(we), 32'd0);
    checkOutput("err_held", 32'(er), 32'd1);

    restart = 1'b1;
    tick();
    restart = 1'b0;
    checkOutput("restart_err", 32'(er), 32'd0);
    checkOutput("restart_count", 32'(cnt), 32'd0);
    checkOutput("restart_halt", 32'(hlt), 32'd0);
    checkClear(4);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'hC0 + 8'(i), (i == 3));
      checkWrite($sformatf("full%0d", i), 8'(i), 8'hC0 + 8'(i));
    end
    checkOutput("full_run", 32'(run), 32'd1);
    checkOutput("full_err", 32'(er), 32'd0);
    checkOutput("full_count", 32'(cnt), 32'd4);
    in_valid = 1'b0;
    in_last  = 1'b0;

    mem_instr = 8'b1101_0111;
    tick();
    checkOutput("d4_match_halt", 32'(hlt), 32'd1);
    checkOutput("d4_match_run", 32'(run), 32'd0);
    mem_instr = 8'h00;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checkClear(4);

    applyStimulus(1'b1, 8'h5A, 1'b0);
    checkWrite("gap0", 8'd0, 8'h5A);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("gap_we", 32'(we), 32'd0);
    checkOutput("gap_count", 32'(cnt), 32'd1);
    checkOutput("gap_ready", 32'(rdy), 32'd1);
    applyStimulus(1'b1, 8'h6B, 1'b0);
    checkWrite("gap1", 8'd1, 8'h6B);
    checkOutput("gap1_count", 32'(cnt), 32'd2);

    in_valid = 1'b1;
    in_data  = 8'h7C;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_we", 32'(we), 32'd0);
    checkOutput("abort_count", 32'(cnt), 32'd0);
    checkOutput("abort_ready", 32'(rdy), 32'd0);
    checkOutput("abort_addr", 32'(addr), 32'd0);
    checkOutput("abort_wdata", 32'(wd), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("abort_hold%0d_we", i), 32'(we), 32'd0);
    end
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
